// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry scanner.
// Contents:
//   KEY_BS, KEY_CLR  edit key codes (backspace, clear-all)
//   db_state_e       debouncer state encoding
//   row_hit_t        per-column row decode result
//   col_drive()      column select -> one-hot-low column drive
//   key_at()         (column, row index) -> key code
//   decode_row()     active-low row bus -> row_hit_t
package keypad_pkg;

    localparam logic [3:0] KEY_BS  = 4'hE;
    localparam logic [3:0] KEY_CLR = 4'hF;

    typedef enum logic [1:0] {
        DbIdle,
        DbCand,
        DbPressed
    } db_state_e;

    typedef struct packed {
        logic       hit;    // at least one active row
        logic       multi;  // two or more active rows
        logic [3:0] code;   // code of the topmost active row
    } row_hit_t;

    function automatic logic [3:0] col_drive(input logic [1:0] sel);
        logic [3:0] drive;
        unique case (sel)
            2'd0: drive = 4'b0111;
            2'd1: drive = 4'b1011;
            2'd2: drive = 4'b1101;
            default: drive = 4'b1110;
        endcase
        return drive;
    endfunction

    function automatic logic [3:0] key_at(input logic [1:0] c, input logic [1:0] r);
        logic [3:0] code;
        unique case ({c, r})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h4;
            4'b00_10: code = 4'h7;
            4'b00_11: code = 4'h0;
            4'b01_00: code = 4'h2;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h8;
            4'b01_11: code = 4'hF;
            4'b10_00: code = 4'h3;
            4'b10_01: code = 4'h6;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hE;
            4'b11_00: code = 4'hA;
            4'b11_01: code = 4'hB;
            4'b11_10: code = 4'hC;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    // Row bit 3 is the top row; a low bit means that row is active.
    function automatic row_hit_t decode_row(input logic [1:0] c, input logic [3:0] row);
        row_hit_t   res;
        logic [3:0] act;
        logic [1:0] idx;
        act = ~row;
        if (act[3]) begin
            idx = 2'd0;
        end else if (act[2]) begin
            idx = 2'd1;
        end else if (act[1]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        res.hit   = (act != 4'b0000);
        res.multi = ((act & (act - 4'd1)) != 4'b0000);
        res.code  = key_at(c, idx);
        return res;
    endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Frame-level debouncer: one event per physical press.
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   frame_end_i        strobe: frame result below is valid this cycle
//   frame_key_i        frame saw exactly one key (0 = NONE or GHOST)
//   frame_code_i       code of that key
//   discard_i          drop an event that would register this cycle
//   press_o            combinational: an event registers on this edge
//   press_code_o       code carried by press_o
//   key_valid_o        registered 1-cycle event pulse
//   key_code_o         registered code of the last accepted event
module keypad_frame_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       frame_end_i,
    input  logic       frame_key_i,
    input  logic [3:0] frame_code_i,
    input  logic       discard_i,
    output logic       press_o,
    output logic [3:0] press_code_o,
    output logic       key_valid_o,
    output logic [3:0] key_code_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(DEBOUNCE_FRAMES - 1);

    db_state_e       state_q;
    logic [CntW-1:0] cnt_q;
    logic [3:0]      cand_q;
    logic            key_valid_q;
    logic [3:0]      key_code_q;

    // The buffer in the top level must act on the same edge that raises key_valid,
    // so the accept condition is exposed before the register.
    always_comb begin
        press_o      = 1'b0;
        press_code_o = frame_code_i;
        if (frame_end_i && frame_key_i) begin
            if (state_q == DbIdle && DEBOUNCE_FRAMES == 1) begin
                press_o = 1'b1;
            end else if (state_q == DbCand && frame_code_i == cand_q && cnt_q == LastCnt) begin
                press_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= DbIdle;
            cnt_q       <= '0;
            cand_q      <= 4'h0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
        end else begin
            key_valid_q <= press_o & ~discard_i;
            if (press_o && !discard_i) begin
                key_code_q <= frame_code_i;
            end
            if (frame_end_i) begin
                unique case (state_q)
                    DbIdle: begin
                        if (frame_key_i) begin
                            cand_q <= frame_code_i;
                            if (DEBOUNCE_FRAMES == 1) begin
                                state_q <= DbPressed;
                                cnt_q   <= '0;
                            end else begin
                                state_q <= DbCand;
                                cnt_q   <= CntW'(1);
                            end
                        end
                    end
                    DbCand: begin
                        if (!frame_key_i) begin
                            state_q <= DbIdle;
                            cnt_q   <= '0;
                        end else if (frame_code_i == cand_q) begin
                            if (cnt_q == LastCnt) begin
                                state_q <= DbPressed;
                                cnt_q   <= '0;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end else begin
                            cand_q <= frame_code_i;
                            cnt_q  <= CntW'(1);
                        end
                    end
                    DbPressed: begin
                        // cnt_q counts consecutive NONE frames towards release.
                        if (frame_key_i) begin
                            cnt_q <= '0;
                        end else if (cnt_q == LastCnt) begin
                            state_q <= DbIdle;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= DbIdle;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign key_valid_o = key_valid_q;
    assign key_code_o  = key_code_q;

endmodule

// File: rtl/keypad_entry_scanner.sv
// 4x4 keypad column scanner, frame accumulator and entry buffer.
// Ports:
//   clk_100MHz   system clock
//   reset        synchronous active-high reset
//   row          keypad rows, active-low
//   clear_in     synchronous buffer clear (scanning continues)
//   col          column drive, one-hot-low
//   key_valid    1-cycle pulse per accepted press
//   key_code     code of the last accepted press
//   entry_bus    stored digits, digit i at [4i+3:4i]
//   entry_count  number of stored digits
//   field_done   pulse when entry_count reaches a multiple of DIGITS_PER_FIELD
//   entry_full   level: buffer full
//   overflow     pulse when a data key is dropped on a full buffer
module keypad_entry_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_TICKS       = 100000,
    parameter int unsigned SETTLE           = 10,
    parameter int unsigned DEBOUNCE_FRAMES  = 3,
    parameter int unsigned NUM_FIELDS       = 2,
    parameter int unsigned DIGITS_PER_FIELD = 4,
    parameter int unsigned EDIT_EN          = 1,
    localparam int unsigned Total           = NUM_FIELDS * DIGITS_PER_FIELD,
    localparam int unsigned CountW          = $clog2(Total + 1)
) (
    input  logic                 clk_100MHz,
    input  logic                 reset,
    input  logic [3:0]           row,
    input  logic                 clear_in,
    output logic [3:0]           col,
    output logic                 key_valid,
    output logic [3:0]           key_code,
    output logic [4*Total-1:0]   entry_bus,
    output logic [CountW-1:0]    entry_count,
    output logic                 field_done,
    output logic                 entry_full,
    output logic                 overflow
);

    localparam int unsigned TimerW = $clog2(SCAN_TICKS);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(SCAN_TICKS - 1);
    localparam logic [TimerW-1:0] SettleT   = TimerW'(SETTLE);
    localparam logic [TimerW-1:0] FrameEndT = TimerW'(SETTLE + 1);
    localparam logic [CountW-1:0] TotalC    = CountW'(Total);

    logic [TimerW-1:0] timer_q;
    logic [1:0]        col_sel_q;
    logic              acc_hit_q, acc_ghost_q;
    logic [3:0]        acc_code_q;
    logic              sample, frame_end;
    row_hit_t          rh;

    assign sample    = (timer_q == SettleT);
    assign frame_end = (col_sel_q == 2'd3) && (timer_q == FrameEndT);
    assign rh        = decode_row(col_sel_q, row);
    assign col       = col_drive(col_sel_q);

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            timer_q     <= '0;
            col_sel_q   <= 2'd0;
            acc_hit_q   <= 1'b0;
            acc_ghost_q <= 1'b0;
            acc_code_q  <= 4'h0;
        end else begin
            if (timer_q == TimerLast) begin
                timer_q   <= '0;
                col_sel_q <= col_sel_q + 2'd1;
            end else begin
                timer_q <= timer_q + 1'b1;
            end
            if (frame_end) begin
                acc_hit_q   <= 1'b0;
                acc_ghost_q <= 1'b0;
                acc_code_q  <= 4'h0;
            end else if (sample && rh.hit) begin
                // A second active row, or a key already seen in an earlier column, is a ghost.
                if (rh.multi || acc_hit_q) begin
                    acc_ghost_q <= 1'b1;
                end else begin
                    acc_code_q <= rh.code;
                end
                acc_hit_q <= 1'b1;
            end
        end
    end

    logic       press;
    logic [3:0] press_code;

    keypad_frame_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk_i        (clk_100MHz),
        .reset_i      (reset),
        .frame_end_i  (frame_end),
        .frame_key_i  (acc_hit_q & ~acc_ghost_q),
        .frame_code_i (acc_code_q),
        .discard_i    (clear_in),
        .press_o      (press),
        .press_code_o (press_code),
        .key_valid_o  (key_valid),
        .key_code_o   (key_code)
    );

    logic [4*Total-1:0] entry_q, entry_d;
    logic [CountW-1:0]  count_q, count_d;
    logic               field_done_q, field_done_d;
    logic               overflow_q, overflow_d;

    always_comb begin
        entry_d      = entry_q;
        count_d      = count_q;
        field_done_d = 1'b0;
        overflow_d   = 1'b0;
        if (clear_in) begin
            entry_d = '0;
            count_d = '0;
        end else if (press) begin
            if (EDIT_EN != 0 && press_code == KEY_BS) begin
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                    entry_d[4*(int'(count_q)-1) +: 4] = 4'h0;
                end
            end else if (EDIT_EN != 0 && press_code == KEY_CLR) begin
                entry_d = '0;
                count_d = '0;
            end else if (count_q < TotalC) begin
                entry_d[4*int'(count_q) +: 4] = press_code;
                count_d      = count_q + 1'b1;
                field_done_d = ((int'(count_d) % DIGITS_PER_FIELD) == 0);
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            entry_q      <= '0;
            count_q      <= '0;
            field_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            entry_q      <= entry_d;
            count_q      <= count_d;
            field_done_q <= field_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign entry_bus   = entry_q;
    assign entry_count = count_q;
    assign field_done  = field_done_q;
    assign overflow    = overflow_q;
    assign entry_full  = (count_q == TotalC);

endmodule

// File: tb/tb_keypad_entry_scanner.sv
// Self-checking bench for keypad_entry_scanner with a small keypad model.
module tb_keypad_entry_scanner;

    localparam int Frame = 80;  // 4 columns x 20 ticks

    logic        clk;
    logic        reset;
    logic [3:0]  row;
    logic        clear_in;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [31:0] entry_bus;
    logic [3:0]  entry_count;
    logic        field_done;
    logic        entry_full;
    logic        overflow;

    keypad_entry_scanner #(
        .SCAN_TICKS       (20),
        .SETTLE           (2),
        .DEBOUNCE_FRAMES  (2),
        .NUM_FIELDS       (2),
        .DIGITS_PER_FIELD (4),
        .EDIT_EN          (1)
    ) dut (
        .clk_100MHz  (clk),
        .reset       (reset),
        .row         (row),
        .clear_in    (clear_in),
        .col         (col),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .entry_bus   (entry_bus),
        .entry_count (entry_count),
        .field_done  (field_done),
        .entry_full  (entry_full),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad layout: {column, row index} of each key.
    function automatic logic [3:0] key_pos(input logic [3:0] k);
        logic [3:0] p;
        case (k)
            4'h1: p = 4'b0000; 4'h4: p = 4'b0001; 4'h7: p = 4'b0010; 4'h0: p = 4'b0011;
            4'h2: p = 4'b0100; 4'h5: p = 4'b0101; 4'h8: p = 4'b0110; 4'hF: p = 4'b0111;
            4'h3: p = 4'b1000; 4'h6: p = 4'b1001; 4'h9: p = 4'b1010; 4'hE: p = 4'b1011;
            4'hA: p = 4'b1100; 4'hB: p = 4'b1101; 4'hC: p = 4'b1110; default: p = 4'b1111;
        endcase
        return p;
    endfunction

    logic [15:0] keys;

    always_comb begin
        row = 4'hF;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] p;
            p = key_pos(4'(k));
            if (keys[k] && col[3 - int'(p[3:2])] == 1'b0) begin
                row[3 - int'(p[1:0])] = 1'b0;
            end
        end
    end

    int cyc = 0;
    int n_kv = 0, n_fd = 0, n_ovf = 0, last_kv_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (key_valid) begin
            n_kv        <= n_kv + 1;
            last_kv_cyc <= cyc;
        end
        if (field_done) n_fd <= n_fd + 1;
        if (overflow) n_ovf <= n_ovf + 1;
    end

    int n_tests = 0, n_fail = 0;
    int base = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic frames(input int n);
        repeat (n * Frame) @(negedge clk);
    endtask

    task automatic press_key(input logic [3:0] k, input int hold, input int gap);
        keys    = '0;
        keys[k] = 1'b1;
        frames(hold);
        keys = '0;
        frames(gap);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " col"}, 32'(col), 32'h7);
        check({tag, " key_valid"}, 32'(key_valid), 32'h0);
        check({tag, " key_code"}, 32'(key_code), 32'h0);
        check({tag, " entry_bus"}, entry_bus, 32'h0);
        check({tag, " entry_count"}, 32'(entry_count), 32'h0);
        check({tag, " flags"}, {29'h0, field_done, entry_full, overflow}, 32'h0);
    endtask

    typedef struct {
        logic [3:0]  k;
        int          hold;
        int          gap;
        int          kv;
        int          fd;
        int          ovf;
        int          cnt;
        logic [3:0]  code;
        logic        full;
        logic [31:0] bus;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] k, input int hold, input int gap, input int kv,
                       input int fd, input int ovf, input int cnt, input logic [3:0] code,
                       input logic full, input logic [31:0] bus);
        vec_t v;
        v.k = k; v.hold = hold; v.gap = gap; v.kv = kv; v.fd = fd; v.ovf = ovf;
        v.cnt = cnt; v.code = code; v.full = full; v.bus = bus;
        vecs.push_back(v);
    endtask

    initial begin
        int kv0, fd0, ov0;
        reset    = 1'b1;
        clear_in = 1'b0;
        keys     = '0;

        //       key  hold gap kv fd ov cnt code full bus
        add(4'hF, 2, 2, 1, 0, 0, 0, 4'hF, 0, 32'h0);
        add(4'h3, 2, 3, 1, 0, 0, 1, 4'h3, 0, 32'h3);
        add(4'h3, 2, 2, 1, 0, 0, 2, 4'h3, 0, 32'h33);
        add(4'hF, 2, 2, 1, 0, 0, 0, 4'hF, 0, 32'h0);
        add(4'h1, 2, 2, 1, 0, 0, 1, 4'h1, 0, 32'h1);
        add(4'h2, 2, 2, 1, 0, 0, 2, 4'h2, 0, 32'h21);
        add(4'h3, 2, 2, 1, 0, 0, 3, 4'h3, 0, 32'h321);
        add(4'h4, 2, 2, 1, 1, 0, 4, 4'h4, 0, 32'h4321);
        add(4'hA, 2, 2, 1, 0, 0, 5, 4'hA, 0, 32'hA4321);
        add(4'hB, 2, 2, 1, 0, 0, 6, 4'hB, 0, 32'hBA4321);
        add(4'hC, 2, 2, 1, 0, 0, 7, 4'hC, 0, 32'hCBA4321);
        add(4'hD, 2, 2, 1, 1, 0, 8, 4'hD, 1, 32'hDCBA4321);
        add(4'h7, 2, 2, 1, 0, 1, 8, 4'h7, 1, 32'hDCBA4321);
        add(4'hF, 2, 2, 1, 0, 0, 0, 4'hF, 0, 32'h0);
        add(4'h8, 1, 2, 0, 0, 0, 0, 4'hF, 0, 32'h0);
        add(4'h9, 2, 2, 1, 0, 0, 1, 4'h9, 0, 32'h9);
        add(4'h6, 2, 2, 1, 0, 0, 2, 4'h6, 0, 32'h69);
        add(4'hE, 2, 2, 1, 0, 0, 1, 4'hE, 0, 32'h9);
        add(4'hE, 2, 2, 1, 0, 0, 0, 4'hE, 0, 32'h0);
        add(4'hE, 2, 2, 1, 0, 0, 0, 4'hE, 0, 32'h0);
        add(4'h4, 2, 2, 1, 0, 0, 1, 4'h4, 0, 32'h4);
        add(4'h4, 2, 2, 1, 0, 0, 2, 4'h4, 0, 32'h44);
        add(4'hF, 2, 2, 1, 0, 0, 0, 4'hF, 0, 32'h0);

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        base  = cyc;

        // Hold '5' for 4 frames: one event at the end of frame 2.
        kv0 = n_kv;
        press_key(4'h5, 4, 2);
        check("five events", n_kv - kv0, 1);
        check("five event cycle", last_kv_cyc - base, 2 * Frame - 16);
        check("five code", 32'(key_code), 32'h5);
        check("five count", 32'(entry_count), 32'h1);
        check("five digit0", entry_bus, 32'h5);

        foreach (vecs[i]) begin
            kv0 = n_kv; fd0 = n_fd; ov0 = n_ovf;
            press_key(vecs[i].k, vecs[i].hold, vecs[i].gap);
            check($sformatf("v%0d key_valid", i), n_kv - kv0, vecs[i].kv);
            check($sformatf("v%0d field_done", i), n_fd - fd0, vecs[i].fd);
            check($sformatf("v%0d overflow", i), n_ovf - ov0, vecs[i].ovf);
            check($sformatf("v%0d count", i), 32'(entry_count), vecs[i].cnt);
            check($sformatf("v%0d code", i), 32'(key_code), 32'(vecs[i].code));
            check($sformatf("v%0d full", i), 32'(entry_full), 32'(vecs[i].full));
            check($sformatf("v%0d bus", i), entry_bus, vecs[i].bus);
        end

        // Ghosts: keys in two columns, then two rows in one column.
        kv0 = n_kv;
        keys = 16'h0006;
        frames(3);
        keys = '0;
        frames(2);
        keys = 16'h0012;
        frames(3);
        keys = '0;
        frames(2);
        check("ghost events", n_kv - kv0, 0);
        check("ghost count", 32'(entry_count), 32'h0);

        // Reset mid-entry (count 5) and mid-press (6 in CAND).
        press_key(4'h1, 2, 2);
        press_key(4'h2, 2, 2);
        press_key(4'h3, 2, 2);
        press_key(4'h4, 2, 2);
        press_key(4'h5, 2, 2);
        check("pre-reset count", 32'(entry_count), 32'h5);
        keys    = '0;
        keys[6] = 1'b1;
        frames(1);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid reset");
        reset = 1'b0;
        base  = cyc;
        kv0   = n_kv;
        frames(3);
        check("post-reset events", n_kv - kv0, 1);
        check("post-reset event cycle", last_kv_cyc - base, 2 * Frame - 16);
        check("post-reset code", 32'(key_code), 32'h6);
        check("post-reset bus", entry_bus, 32'h6);
        keys = '0;
        frames(2);

        // clear_in in the cycle the event would register.
        kv0     = n_kv;
        keys[2] = 1'b1;
        repeat (2 * Frame - 17) @(negedge clk);
        clear_in = 1'b1;
        @(negedge clk);
        clear_in = 1'b0;
        frames(3);
        check("clear events", n_kv - kv0, 0);
        check("clear count", 32'(entry_count), 32'h0);
        check("clear bus", entry_bus, 32'h0);
        check("clear code", 32'(key_code), 32'h6);
        keys = '0;
        frames(2);
        kv0 = n_kv;
        press_key(4'h2, 2, 2);
        check("after clear events", n_kv - kv0, 1);
        check("after clear bus", entry_bus, 32'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
